// File: rtl/lsu_mem_ctrl_if.sv
// Handshake bundles for the load/store unit: core-side request/response and
// the word-wide data-SRAM bus.

interface lsu_req_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  stall, done, rdata, err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output stall, done, rdata, err
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns MIPS byte/half/word accesses into word-aligned SRAM
// transactions with byte enables, stalls the core and extends load data.

module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic      clock,
    input  logic      reset,
    lsu_req_if.slave  req_if,
    lsu_mem_if.master bus_if
);

    typedef enum logic [1:0] {IDLE, BUS, RESP, ERR} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [7:0]  cnt_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q;

    logic        bad_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_d;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        bad_d   = 1'b0;
        be_d    = 4'b1111;
        wdata_d = '0;
        case (req_if.req_size)
            2'b00: begin
                if (req_if.req_write) begin
                    be_d    = 4'b0001 << req_if.req_addr[1:0];
                    wdata_d = {4{req_if.req_wdata[7:0]}};
                end
            end
            2'b01: begin
                bad_d = req_if.req_addr[0];
                if (req_if.req_write) begin
                    be_d    = req_if.req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{req_if.req_wdata[15:0]}};
                end
            end
            2'b10: begin
                bad_d = |req_if.req_addr[1:0];
                if (req_if.req_write) begin
                    wdata_d = req_if.req_wdata;
                end
            end
            default: bad_d = 1'b1;
        endcase
    end

    // Lane select and extension use the offset/size captured at request time.
    always_comb begin
        byte_sel = bus_if.mem_rdata[7:0];
        case (off_q)
            2'd1:    byte_sel = bus_if.mem_rdata[15:8];
            2'd2:    byte_sel = bus_if.mem_rdata[23:16];
            2'd3:    byte_sel = bus_if.mem_rdata[31:24];
            default: byte_sel = bus_if.mem_rdata[7:0];
        endcase
        half_sel = off_q[1] ? bus_if.mem_rdata[31:16] : bus_if.mem_rdata[15:0];
        case (size_q)
            2'b00:   load_d = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_d = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_d = bus_if.mem_rdata;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            off_q    <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_if.req_valid) begin
                        if (bad_d) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q  <= BUS;
                            req_q    <= 1'b1;
                            we_q     <= req_if.req_write;
                            addr_q   <= {req_if.req_addr[31:2], 2'b00};
                            be_q     <= be_d;
                            wdata_q  <= wdata_d;
                            cnt_q    <= '0;
                            off_q    <= req_if.req_addr[1:0];
                            size_q   <= req_if.req_size;
                            signed_q <= req_if.req_signed;
                        end
                    end
                end
                BUS: begin
                    // An ack on the final counted cycle still wins over the timeout.
                    if (bus_if.mem_ack) begin
                        state_q <= RESP;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= load_d;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ERR;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_if.stall = req_if.req_valid & (state_q != RESP) & (state_q != ERR);
    assign req_if.done  = done_q;
    assign req_if.err   = err_q;
    assign req_if.rdata = rdata_q;

    assign bus_if.mem_req   = req_q;
    assign bus_if.mem_we    = we_q;
    assign bus_if.mem_addr  = addr_q;
    assign bus_if.mem_be    = be_q;
    assign bus_if.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed loads/stores push expected bus
// and response records; monitors pop and compare when the DUT presents them.

module tb_lsu_mem_ctrl;

    localparam int TO = 4;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [31:0] rdata;
        bit          chk_rdata;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          nreq;
    } bus_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    lsu_req_if req_if ();
    lsu_mem_if mem_if ();

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clock  (clock),
        .reset  (reset),
        .req_if (req_if),
        .bus_if (mem_if)
    );

    resp_t       resp_q[$];
    bus_t        bus_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mem_wait = 0;
    logic [31:0] mem_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // SRAM model: acks after mem_wait stall cycles of a continuous request.
    int wcnt = 0;
    always @(negedge clock) begin
        if (mem_if.mem_req) begin
            if (wcnt == mem_wait) begin
                mem_if.mem_ack   = 1'b1;
                mem_if.mem_rdata = mem_word;
            end else begin
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = 32'h5A5A_5A5A;
            end
            wcnt++;
        end else begin
            mem_if.mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Response, stall and bus monitor.
    resp_t e;
    bus_t  cur;
    bit    cur_valid = 1'b0;
    logic  prev_req = 1'b0;
    int    req_cnt = 0;
    always @(negedge clock) begin
        check("stall", {31'b0, req_if.stall},
              {31'b0, req_if.req_valid & ~(req_if.done | req_if.err)});
        if (req_if.done | req_if.err) begin
            if (resp_q.size() == 0) begin
                check("spurious_resp", {30'b0, req_if.done, req_if.err}, 32'd0);
            end else begin
                e = resp_q.pop_front();
                check("resp_kind", {30'b0, req_if.done, req_if.err}, e.is_err ? 32'd1 : 32'd2);
                check("resp_cycle", cyc, e.cyc);
                if (e.chk_rdata) check("rdata", req_if.rdata, e.rdata);
            end
        end
        if (mem_if.mem_req && !prev_req) begin
            if (bus_q.size() == 0) begin
                check("spurious_req", {31'b0, mem_if.mem_req}, 32'd0);
                cur_valid = 1'b0;
            end else begin
                cur = bus_q.pop_front();
                cur_valid = 1'b1;
                req_cnt = 1;
                check("mem_addr", mem_if.mem_addr, cur.addr);
                check("mem_be", {28'b0, mem_if.mem_be}, {28'b0, cur.be});
                check("mem_we", {31'b0, mem_if.mem_we}, {31'b0, cur.we});
                check("mem_wdata", mem_if.mem_wdata, cur.wdata);
            end
        end else if (mem_if.mem_req) begin
            req_cnt++;
        end else if (prev_req && cur_valid && cur.nreq != 0) begin
            check("mem_req_cycles", req_cnt, cur.nreq);
        end
        prev_req = mem_if.mem_req;
    end

    // Issue one request at posedge+1 and wait for its done/err.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int waitc, input logic [31:0] word,
                         input logic [3:0] ebe, input logic [31:0] ewd,
                         input bit bad, input logic [31:0] erd, input bit chk,
                         input bit keep);
        resp_t r;
        bus_t  b;
        bit    seen;
        seen = 1'b0;
        mem_wait = waitc;
        mem_word = word;
        req_if.req_write  = wr;
        req_if.req_size   = sz;
        req_if.req_signed = sg;
        req_if.req_addr   = addr;
        req_if.req_wdata  = wd;
        req_if.req_valid  = 1'b1;
        r.chk_rdata = chk;
        r.rdata     = erd;
        if (bad) begin
            r.is_err = 1'b1;
            r.cyc    = cyc + 1;
        end else begin
            b.addr  = {addr[31:2], 2'b00};
            b.be    = ebe;
            b.we    = wr;
            b.wdata = ewd;
            b.nreq  = (waitc >= TO) ? TO : waitc + 1;
            bus_q.push_back(b);
            r.is_err = (waitc >= TO);
            r.cyc    = (waitc >= TO) ? cyc + TO + 1 : cyc + waitc + 2;
        end
        resp_q.push_back(r);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = req_if.done | req_if.err;
        end
        if (!seen) check("resp_timeout", {31'b0, req_if.done | req_if.err}, 32'd1);
        @(posedge clock);
        #1;
        if (!keep) req_if.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_t b;
        req_if.req_valid  = 1'b0;
        req_if.req_write  = 1'b0;
        req_if.req_size   = 2'b00;
        req_if.req_signed = 1'b0;
        req_if.req_addr   = '0;
        req_if.req_wdata  = '0;
        mem_if.mem_ack    = 1'b0;
        mem_if.mem_rdata  = '0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_if.mem_we}, 32'd0);
        check("rst_mem_be", {28'b0, mem_if.mem_be}, 32'd0);
        check("rst_mem_addr", mem_if.mem_addr, 32'd0);
        check("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
        check("rst_done", {31'b0, req_if.done}, 32'd0);
        check("rst_err", {31'b0, req_if.err}, 32'd0);
        check("rst_rdata", req_if.rdata, 32'd0);
        check("rst_stall", {31'b0, req_if.stall}, 32'd0);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;

        // Loads: wr sz sg addr wdata wait word | be wdata bad rdata chk keep
        issue(0, 2'b10, 0, 32'h10, 0, 0, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'hDEAD_BEEF, 1, 0);
        issue(0, 2'b00, 1, 32'h13, 0, 0, 32'h80FF_0000, 4'hF, 0, 0, 32'hFFFF_FF80, 1, 0);
        issue(0, 2'b00, 0, 32'h13, 0, 0, 32'h80FF_0000, 4'hF, 0, 0, 32'h0000_0080, 1, 0);
        issue(0, 2'b00, 1, 32'h11, 0, 2, 32'h80FF_0000, 4'hF, 0, 0, 32'h0000_0000, 1, 0);
        issue(0, 2'b01, 1, 32'h12, 0, 0, 32'h80FF_0000, 4'hF, 0, 0, 32'hFFFF_80FF, 1, 0);
        issue(0, 2'b01, 0, 32'h12, 0, 0, 32'h80FF_0000, 4'hF, 0, 0, 32'h0000_80FF, 1, 0);
        issue(0, 2'b01, 1, 32'h10, 0, 1, 32'h1234_F00D, 4'hF, 0, 0, 32'hFFFF_F00D, 1, 0);

        // Misaligned and reserved size: err, no bus, rdata held.
        issue(0, 2'b10, 0, 32'h06, 0, 0, 0, 4'hF, 0, 1, 32'hFFFF_F00D, 1, 0);
        issue(0, 2'b01, 0, 32'h21, 0, 0, 0, 4'hF, 0, 1, 32'hFFFF_F00D, 1, 0);
        issue(0, 2'b11, 0, 32'h20, 0, 0, 0, 4'hF, 0, 1, 32'hFFFF_F00D, 1, 0);

        // Stores: lane enables and replicated data.
        issue(1, 2'b01, 0, 32'h22, 32'h1234_ABCD, 3, 0, 4'b1100, 32'hABCD_ABCD, 0, 0, 0, 0);
        issue(1, 2'b00, 0, 32'h31, 32'h0000_00A5, 1, 0, 4'b0010, 32'hA5A5_A5A5, 0, 0, 0, 0);
        issue(1, 2'b10, 0, 32'h44, 32'hCAFE_F00D, 0, 0, 4'b1111, 32'hCAFE_F00D, 0, 0, 0, 0);
        issue(1, 2'b01, 0, 32'h40, 32'hFFFF_5678, 0, 0, 4'b0011, 32'h5678_5678, 0, 0, 0, 0);
        issue(1, 2'b00, 0, 32'h43, 32'h1234_5677, 0, 0, 4'b1000, 32'h7777_7777, 0, 0, 0, 0);

        // Timeout: no ack ever.
        issue(0, 2'b10, 0, 32'h50, 0, 255, 0, 4'hF, 0, 0, 0, 0, 0);

        // Back-to-back: second request accepted in the IDLE cycle after RESP.
        issue(0, 2'b10, 0, 32'h60, 0, 0, 32'h1111_1111, 4'hF, 0, 0, 32'h1111_1111, 1, 1);
        issue(0, 2'b10, 0, 32'h64, 0, 0, 32'h2222_2222, 4'hF, 0, 0, 32'h2222_2222, 1, 0);

        // Reset while waiting in BUS.
        mem_wait = 255;
        b.addr = 32'h70; b.be = 4'hF; b.we = 1'b0; b.wdata = '0; b.nreq = 0;
        bus_q.push_back(b);
        req_if.req_write  = 1'b0;
        req_if.req_size   = 2'b10;
        req_if.req_addr   = 32'h70;
        req_if.req_valid  = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check("pre_rst_req", {31'b0, mem_if.mem_req}, 32'd1);
        #2;
        reset = 1'b0;
        req_if.req_valid = 1'b0;
        #1;
        check("async_req_drop", {31'b0, mem_if.mem_req}, 32'd0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("post_rst_rdata", req_if.rdata, 32'd0);
        issue(0, 2'b10, 0, 32'h74, 0, 0, 32'h0F0F_0F0F, 4'hF, 0, 0, 32'h0F0F_0F0F, 1, 0);

        repeat (3) @(posedge clock);
        #1;
        check("resp_q_left", resp_q.size(), 32'd0);
        check("bus_q_left", bus_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
